// File: rtl/native_pkg.sv
// rtl/native_pkg.sv - shared widths, burst geometry, FSM states and command type for the native port responder
package native_pkg;

    localparam int DDR_ADDR_W      = 32;
    localparam int DDR_DATA_W      = 256;
    localparam int DDR_MASK_W      = DDR_DATA_W / 8;

    localparam int BURST_BYTES     = 64;
    localparam int BEATS_PER_BURST = 2;

    // Byte-offset bits inside one burst, and inside one beat
    localparam int BURST_OFS_W     = $clog2(BURST_BYTES);
    localparam int BEAT_OFS_W      = $clog2(BURST_BYTES / BEATS_PER_BURST);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR0,
        ST_WR1,
        ST_RD0,
        ST_RD1
    } rsp_state_e;

    typedef struct packed {
        logic [DDR_ADDR_W-1:0] addr;
        logic                  we;
        logic                  mw;
    } ncmd_t;

endpackage

// File: rtl/native_cmd_fifo.sv
// rtl/native_cmd_fifo.sv - power-of-two deep queue of native commands
module native_cmd_fifo
    import native_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  ncmd_t push_data,
    input  logic  pop,
    output ncmd_t pop_data,
    output logic  full,
    output logic  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    ncmd_t            slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Fullness is judged before this cycle's pop, so a push to a full queue waits a cycle
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = slots[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Command storage; only the pointers need a reset
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/native_port_responder.sv
// rtl/native_port_responder.sv - native-port target endpoint over a 1-cycle SRAM; NATIVE_RSP_PERF_CNT_EN adds command counters
module native_port_responder #(
    parameter int DDR_ADDR_W = 32,
    parameter int DDR_DATA_W = 256,
    parameter int DDR_MASK_W = 32,
    parameter int MEM_WORDS  = 64,
    parameter int CMD_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    input  logic                         ncmd_valid_i,
    output logic                         ncmd_ready_o,
    input  logic [DDR_ADDR_W-1:0]        ncmd_payload_addr_i,
    input  logic                         ncmd_payload_we_i,
    input  logic                         ncmd_payload_mw_i,
    input  logic                         wdata_valid_i,
    output logic                         wdata_ready_o,
    input  logic [DDR_DATA_W-1:0]        wdata_payload_data_i,
    input  logic [DDR_MASK_W-1:0]        wdata_payload_we_i,
    output logic                         rdata_valid_o,
    input  logic                         rdata_ready_i,
    output logic [DDR_DATA_W-1:0]        rdata_payload_data_o,
    output logic                         mem_en_o,
    output logic                         mem_we_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    output logic [DDR_DATA_W-1:0]        mem_wdata_o,
    output logic [DDR_MASK_W-1:0]        mem_bmask_o,
    input  logic [DDR_DATA_W-1:0]        mem_rdata_i,
    output logic                         err_o
`ifdef NATIVE_RSP_PERF_CNT_EN
    ,
    output logic [15:0]                  wr_cnt_o,
    output logic [15:0]                  rd_cnt_o
`endif
);

    import native_pkg::*;

    localparam int MEM_AW = $clog2(MEM_WORDS);

    rsp_state_e             state_q;
    rsp_state_e             state_d;
    ncmd_t                  cmd_in;
    ncmd_t                  cmd_head;
    logic                   q_full;
    logic                   q_empty;
    logic                   q_pop;
    logic [MEM_AW-1:0]      base_q;
    logic                   mw_q;
    logic                   err_q;
    logic                   misaligned;
    logic                   rd_issue;
    logic                   rd_inflight_q;
    logic [DDR_DATA_W-1:0]  buf_data [2];
    logic                   buf_wr_ptr;
    logic                   buf_rd_ptr;
    logic [1:0]             buf_cnt;
    logic [1:0]             outstanding;
    logic                   buf_pop;
    logic                   unused_addr_hi;

    assign cmd_in = '{addr: ncmd_payload_addr_i, we: ncmd_payload_we_i, mw: ncmd_payload_mw_i};

    native_cmd_fifo #(
        .DEPTH     (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ncmd_valid_i),
        .push_data (cmd_in),
        .pop       (q_pop),
        .pop_data  (cmd_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign ncmd_ready_o   = !q_full;
    assign misaligned     = |cmd_head.addr[BURST_OFS_W-1:0];
    assign unused_addr_hi = ^cmd_head.addr[DDR_ADDR_W-1:BEAT_OFS_W+MEM_AW];
    assign err_o          = err_q;

    // Read beats already owed to the consumer: buffered plus the one returning from SRAM
    assign outstanding          = buf_cnt + {1'b0, rd_inflight_q};
    assign rdata_valid_o        = (buf_cnt != 2'd0);
    assign rdata_payload_data_o = rdata_valid_o ? buf_data[buf_rd_ptr] : '0;
    assign buf_pop              = rdata_valid_o && rdata_ready_i;

    // Burst sequencer: next state and SRAM port drive
    always_comb begin
        state_d       = state_q;
        q_pop         = 1'b0;
        wdata_ready_o = 1'b0;
        mem_en_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_bmask_o   = '0;
        rd_issue      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    q_pop   = 1'b1;
                    state_d = cmd_head.we ? ST_WR0 : ST_RD0;
                end
            end
            ST_WR0, ST_WR1: begin
                wdata_ready_o = 1'b1;
                if (wdata_valid_i) begin
                    mem_en_o    = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = base_q + MEM_AW'(state_q == ST_WR1);
                    mem_wdata_o = wdata_payload_data_i;
                    mem_bmask_o = mw_q ? wdata_payload_we_i : '1;
                    state_d     = (state_q == ST_WR0) ? ST_WR1 : ST_IDLE;
                end
            end
            ST_RD0, ST_RD1: begin
                if (outstanding < 2'd2) begin
                    mem_en_o   = 1'b1;
                    rd_issue   = 1'b1;
                    mem_addr_o = base_q + MEM_AW'(state_q == ST_RD1);
                    state_d    = (state_q == ST_RD0) ? ST_RD1 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state, latched burst base and sticky misalignment flag (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            mw_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (q_pop) begin
                base_q <= cmd_head.addr[BEAT_OFS_W +: MEM_AW];
                mw_q   <= cmd_head.mw;
            end
            if (q_pop && misaligned) begin
                err_q <= 1'b1;
            end else if (clr_i) begin
                err_q <= 1'b0;
            end
        end
    end

    // Return-buffer occupancy; SRAM data lands in the buffer the cycle after issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_inflight_q <= 1'b0;
            buf_wr_ptr    <= 1'b0;
            buf_rd_ptr    <= 1'b0;
            buf_cnt       <= 2'd0;
        end else begin
            rd_inflight_q <= rd_issue;
            if (rd_inflight_q) buf_wr_ptr <= ~buf_wr_ptr;
            if (buf_pop)       buf_rd_ptr <= ~buf_rd_ptr;
            buf_cnt <= buf_cnt + {1'b0, rd_inflight_q} - {1'b0, buf_pop};
        end
    end

    // Return-buffer storage; the output mux hides stale entries
    always_ff @(posedge clk) begin
        if (rd_inflight_q) buf_data[buf_wr_ptr] <= mem_rdata_i;
    end

`ifdef NATIVE_RSP_PERF_CNT_EN
    logic wr_done;
    logic rd_done;

    assign wr_done = mem_we_o && (state_q == ST_WR1);
    assign rd_done = rd_issue && (state_q == ST_RD1);

    // Saturating counts of completed write and read commands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_o <= 16'd0;
            rd_cnt_o <= 16'd0;
        end else if (clr_i) begin
            wr_cnt_o <= 16'd0;
            rd_cnt_o <= 16'd0;
        end else begin
            if (wr_done && (wr_cnt_o != 16'hFFFF)) wr_cnt_o <= wr_cnt_o + 16'd1;
            if (rd_done && (rd_cnt_o != 16'hFFFF)) rd_cnt_o <= rd_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_native_port_responder.sv
// tb/tb_native_port_responder.sv - directed self-checking bench for native_port_responder
module tb_native_port_responder;

    localparam logic [255:0] DAT_A  = {8{32'hAAAA_0001}};
    localparam logic [255:0] DAT_B  = {8{32'hBBBB_0002}};
    localparam logic [255:0] DAT_C  = {8{32'hCCCC_0003}};
    localparam logic [255:0] DAT_D  = {8{32'hDDDD_0004}};
    localparam logic [255:0] DAT_P0 = {32{8'h11}};
    localparam logic [255:0] DAT_P1 = {32{8'h22}};
    localparam logic [255:0] DAT_N0 = {32{8'hEE}};
    localparam logic [255:0] DAT_N1 = {32{8'h33}};
    localparam logic [255:0] DAT_E0 = {{28{8'h11}}, {4{8'hEE}}};
    localparam logic [255:0] EXP_BP [12] = '{DAT_A, DAT_B, DAT_D, DAT_P1, DAT_C, DAT_D,
                                              DAT_P1, DAT_A, DAT_A, DAT_B, DAT_D, DAT_P1};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr_i;
    logic         ncmd_valid_i;
    logic         ncmd_ready_o;
    logic [31:0]  ncmd_payload_addr_i;
    logic         ncmd_payload_we_i;
    logic         ncmd_payload_mw_i;
    logic         wdata_valid_i;
    logic         wdata_ready_o;
    logic [255:0] wdata_payload_data_i;
    logic [31:0]  wdata_payload_we_i;
    logic         rdata_valid_o;
    logic         rdata_ready_i;
    logic [255:0] rdata_payload_data_o;
    logic         mem_en_o;
    logic         mem_we_o;
    logic [5:0]   mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [31:0]  mem_bmask_o;
    logic [255:0] mem_rdata_i;
    logic         err_o;

    always #5 clk = ~clk;

    native_port_responder dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .clr_i                (clr_i),
        .ncmd_valid_i         (ncmd_valid_i),
        .ncmd_ready_o         (ncmd_ready_o),
        .ncmd_payload_addr_i  (ncmd_payload_addr_i),
        .ncmd_payload_we_i    (ncmd_payload_we_i),
        .ncmd_payload_mw_i    (ncmd_payload_mw_i),
        .wdata_valid_i        (wdata_valid_i),
        .wdata_ready_o        (wdata_ready_o),
        .wdata_payload_data_i (wdata_payload_data_i),
        .wdata_payload_we_i   (wdata_payload_we_i),
        .rdata_valid_o        (rdata_valid_o),
        .rdata_ready_i        (rdata_ready_i),
        .rdata_payload_data_o (rdata_payload_data_o),
        .mem_en_o             (mem_en_o),
        .mem_we_o             (mem_we_o),
        .mem_addr_o           (mem_addr_o),
        .mem_wdata_o          (mem_wdata_o),
        .mem_bmask_o          (mem_bmask_o),
        .mem_rdata_i          (mem_rdata_i),
        .err_o                (err_o)
    );

    logic [255:0] sram [64];
    logic [255:0] merge_w;
    int           cycle = 0;
    int           total = 0;
    int           bad   = 0;
    int           rd_issued = 0;
    int           rd_got    = 0;
    int           max_out   = 0;
    logic [5:0]   wr_addr_q [$];
    logic [31:0]  wr_mask_q [$];
    logic [255:0] rd_q      [$];
    int           rd_cyc_q  [$];

    always @(posedge clk) cycle <= cycle + 1;

    // Byte-masked single-port SRAM with one cycle of read latency
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                merge_w = sram[mem_addr_o];
                for (int b = 0; b < 32; b++)
                    if (mem_bmask_o[b]) merge_w[b*8 +: 8] = mem_wdata_o[b*8 +: 8];
                sram[mem_addr_o] <= merge_w;
            end else begin
                mem_rdata_i <= sram[mem_addr_o];
            end
        end
    end

    // Observe SRAM traffic and delivered read beats mid-cycle
    always @(negedge clk) begin
        if (mem_en_o && mem_we_o) begin
            wr_addr_q.push_back(mem_addr_o);
            wr_mask_q.push_back(mem_bmask_o);
        end
        if (mem_en_o && !mem_we_o) rd_issued++;
        if (rd_issued - rd_got > max_out) max_out = rd_issued - rd_got;
        if (rdata_valid_o && rdata_ready_i) begin
            rd_q.push_back(rdata_payload_data_o);
            rd_cyc_q.push_back(cycle);
            rd_got++;
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic we, input logic mw, output int hs);
        bit done = 0;
        hs = -1;
        ncmd_valid_i        = 1'b1;
        ncmd_payload_addr_i = addr;
        ncmd_payload_we_i   = we;
        ncmd_payload_mw_i   = mw;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (ncmd_ready_o) begin
                hs = cycle;
                done = 1;
            end
        end
        if (!done) check_eq("cmd_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        ncmd_valid_i = 1'b0;
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [31:0] m, output int c);
        bit done = 0;
        c = -1;
        wdata_valid_i        = 1'b1;
        wdata_payload_data_i = d;
        wdata_payload_we_i   = m;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (wdata_ready_o) begin
                c = cycle;
                done = 1;
            end
        end
        if (!done) check_eq("wbeat_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        wdata_valid_i = 1'b0;
    endtask

    task automatic wait_reads(input int n);
        for (int i = 0; i < 300 && rd_q.size() < n; i++) @(posedge clk);
        #1;
        check_eq("read_beat_count", rd_q.size(), n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ncmd_ready"}, ncmd_ready_o, 1'b1);
        check_eq({tag, "_wdata_ready"}, wdata_ready_o, 1'b0);
        check_eq({tag, "_rdata_valid"}, rdata_valid_o, 1'b0);
        check_eq({tag, "_mem_en"}, mem_en_o, 1'b0);
        check_eq({tag, "_mem_we"}, mem_we_o, 1'b0);
        check_eq({tag, "_err"}, err_o, 1'b0);
        check_eq({tag, "_rdata"}, rdata_payload_data_o, 256'd0);
        check_eq({tag, "_mem_addr"}, mem_addr_o, 6'd0);
        check_eq({tag, "_mem_wdata"}, mem_wdata_o, 256'd0);
        check_eq({tag, "_mem_bmask"}, mem_bmask_o, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hs;
        int c0;
        int c1;
        int snap_issued;

        rst_n = 1'b0; clr_i = 1'b0;
        ncmd_valid_i = 1'b0; ncmd_payload_addr_i = '0; ncmd_payload_we_i = 1'b0; ncmd_payload_mw_i = 1'b0;
        wdata_valid_i = 1'b0; wdata_payload_data_i = '0; wdata_payload_we_i = '0;
        rdata_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst");

        // Write data offered before any command must be held off
        wdata_valid_i = 1'b1; wdata_payload_data_i = DAT_A; wdata_payload_we_i = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("early_wdata_ready", wdata_ready_o, 1'b0);
        end
        @(posedge clk);
        #1;

        // Burst write to 0x40 then read it back
        wr_addr_q.delete();
        send_cmd(32'h40, 1'b1, 1'b0, hs);
        send_beat(DAT_A, '1, c0);
        check_eq("wr_first_ready_cycle", c0, hs + 2);
        send_beat(DAT_B, '1, c1);
        check_eq("wr_second_beat_cycle", c1, c0 + 1);
        check_eq("wr_addr_count", wr_addr_q.size(), 2);
        check_eq("wr_addr_beat0", wr_addr_q[0], 6'd2);
        check_eq("wr_addr_beat1", wr_addr_q[1], 6'd3);

        rd_q.delete(); rd_cyc_q.delete();
        send_cmd(32'h40, 1'b0, 1'b0, hs);
        wait_reads(2);
        check_eq("rd_beat0_data", rd_q[0], DAT_A);
        check_eq("rd_beat1_data", rd_q[1], DAT_B);
        check_eq("rd_beat0_cycle", rd_cyc_q[0], hs + 4);
        check_eq("rd_beat1_cycle", rd_cyc_q[1], hs + 5);

        // Full write of words 0/1, then a masked overwrite of bytes 0-3 only
        send_cmd(32'h0, 1'b1, 1'b0, hs);
        send_beat(DAT_P0, '1, c0);
        send_beat(DAT_P1, '1, c0);
        wr_mask_q.delete();
        send_cmd(32'h0, 1'b1, 1'b1, hs);
        send_beat(DAT_N0, 32'h0000_000F, c0);
        send_beat(DAT_N1, 32'h0000_0000, c0);
        check_eq("mw_bmask_beat0", wr_mask_q[0], 32'h0000_000F);
        check_eq("mw_bmask_beat1", wr_mask_q[1], 32'h0000_0000);
        rd_q.delete();
        send_cmd(32'h0, 1'b0, 1'b0, hs);
        wait_reads(2);
        check_eq("mw_readback_word0", rd_q[0], DAT_E0);
        check_eq("mw_readback_word1", rd_q[1], DAT_P1);
        check_eq("mw_err_clear", err_o, 1'b0);

        // Misaligned burst at the last word wraps to word 0 and flags err
        wr_addr_q.delete();
        send_cmd(32'h7E0, 1'b1, 1'b0, hs);
        send_beat(DAT_C, '1, c0);
        send_beat(DAT_D, '1, c0);
        @(negedge clk);
        check_eq("wrap_err_set", err_o, 1'b1);
        check_eq("wrap_addr_beat0", wr_addr_q[0], 6'd63);
        check_eq("wrap_addr_beat1", wr_addr_q[1], 6'd0);
        @(posedge clk);
        #1 clr_i = 1'b1;
        @(posedge clk);
        #1 clr_i = 1'b0;
        @(negedge clk);
        check_eq("wrap_err_cleared", err_o, 1'b0);
        @(posedge clk);
        #1;

        // Back-to-back reads with the consumer stalled
        rdata_ready_i = 1'b0;
        rd_q.delete();
        max_out = 0;
        send_cmd(32'h40,  1'b0, 1'b0, hs);
        send_cmd(32'h0,   1'b0, 1'b0, hs);
        send_cmd(32'h7E0, 1'b0, 1'b0, hs);
        send_cmd(32'h20,  1'b0, 1'b0, hs);
        send_cmd(32'h40,  1'b0, 1'b0, hs);
        send_cmd(32'h0,   1'b0, 1'b0, hs);
        repeat (10) @(negedge clk);
        check_eq("bp_queue_full", ncmd_ready_o, 1'b0);
        check_eq("bp_rvalid_held", rdata_valid_o, 1'b1);
        check_eq("bp_head_stable", rdata_payload_data_o, DAT_A);
        check_eq("bp_none_delivered", rd_q.size(), 0);
        @(posedge clk);
        #1 rdata_ready_i = 1'b1;
        wait_reads(12);
        for (int i = 0; i < 12; i++)
            check_eq($sformatf("bp_beat%0d", i), rd_q[i], EXP_BP[i]);
        check_eq("bp_max_outstanding_le2", (max_out <= 2), 1'b1);

        // Reset asserted right after the first beat of a read
        rd_q.delete();
        send_cmd(32'h40, 1'b0, 1'b0, hs);
        send_cmd(32'h0,  1'b0, 1'b0, hs);
        for (int i = 0; i < 50 && rd_q.size() < 1; i++) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        snap_issued = rd_issued;
        repeat (20) @(posedge clk);
        #1;
        check_eq("midrst_no_more_beats", rd_q.size(), 1);
        check_eq("midrst_no_more_issue", rd_issued, snap_issued);
        check_eq("midrst_rvalid_low", rdata_valid_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
